// File: rtl/tick_sched_if.sv
// Config and status bundle for tick_sched.
// Master drives configuration; slave returns per-channel tick/sq/busy.
interface tick_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 25,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_oneshot;
    logic              cfg_en;
    logic              sync_start;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] busy;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_oneshot, cfg_en, sync_start,
        input  tick, sq, busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_oneshot, cfg_en, sync_start,
        output tick, sq, busy
    );
endinterface

// File: rtl/tick_sched.sv
// Shared runtime-programmable tick scheduler, NUM_CH channels.
// Each channel: divisor, periodic/one-shot, tick enable and square output.
module tick_sched #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = 24_999_999
) (
    input  logic  clk_in,
    input  logic  rst_a_n,
    tick_sched_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [CNT_W-1:0] div_q   [NUM_CH];
    logic [CNT_W-1:0] div_d   [NUM_CH];
    logic [NUM_CH-1:0] os_q, os_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic [NUM_CH-1:0] wr;

    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        os_d    = os_q;
        sq_d    = sq_q;
        tick_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr[i]) begin
                div_d[i]   = bus.cfg_div;
                os_d[i]    = bus.cfg_oneshot;
                cnt_d[i]   = '0;
                state_d[i] = bus.cfg_en ? RUN : IDLE;
            end else if (state_q[i] == RUN) begin
                if (bus.sync_start) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                    if (os_q[i]) state_d[i] = IDLE;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_a_n) begin
        if (!rst_a_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
            end
            os_q   <= '0;
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
            end
            os_q   <= os_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    always_comb begin
        bus.busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.busy[i] = (state_q[i] == RUN);
        end
    end

    assign bus.tick = tick_q;
    assign bus.sq   = sq_q;
endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched.
// Second small instance exercises an out-of-range channel select.
module tb_tick_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tick_sched_if #(.NUM_CH(4), .CNT_W(25)) bus ();
    tick_sched_if #(.NUM_CH(3), .CNT_W(4)) sbus ();

    tick_sched #(
        .NUM_CH(4), .CNT_W(25), .DEFAULT_DIV(24_999_999)
    ) u_dut (
        .clk_in(clk), .rst_a_n(rst_n), .bus(bus.slave)
    );

    tick_sched #(
        .NUM_CH(3), .CNT_W(4), .DEFAULT_DIV(5)
    ) u_small (
        .clk_in(clk), .rst_a_n(rst_n), .bus(sbus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int dv, input bit os,
                      input bit en);
        bus.cfg_we      = 1'b1;
        bus.cfg_ch      = 2'(ch);
        bus.cfg_div     = 25'(dv);
        bus.cfg_oneshot = os;
        bus.cfg_en      = en;
        step();
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        logic [11:0] acc;
        bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_div = 0;
        bus.cfg_oneshot = 0; bus.cfg_en = 0; bus.sync_start = 0;
        sbus.cfg_we = 0; sbus.cfg_ch = 0; sbus.cfg_div = 0;
        sbus.cfg_oneshot = 0; sbus.cfg_en = 0; sbus.sync_start = 0;
        repeat (3) step();
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_sq", 32'(bus.sq), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;

        // Idle for 1000 cycles
        acc = '0;
        for (int k = 0; k < 1000; k++) begin
            step();
            acc |= {bus.tick, bus.sq, bus.busy};
        end
        chk("idle_1000", 32'(acc), 0);

        // Periodic ch0 div=4
        wr(0, 4, 0, 1);
        chk("p_busy0", 32'(bus.busy[0]), 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("p_tick0", 32'(bus.tick[0]), 32'(k % 5 == 0));
            chk("p_sq0", 32'(bus.sq[0]), 32'((k / 5) % 2));
        end

        // One-shot ch1 div=2
        wr(1, 2, 1, 1);
        chk("os_busy_start", 32'(bus.busy[1]), 1);
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("os_tick1", 32'(bus.tick[1]), 32'(k == 3));
            chk("os_busy1", 32'(bus.busy[1]), 32'(k < 3));
        end

        // Rewrite on terminal count suppresses the tick
        wr(2, 9, 0, 1);
        repeat (9) step();
        chk("sup_pre", 32'(bus.tick[2]), 0);
        wr(2, 3, 0, 1);
        chk("sup_tick2", 32'(bus.tick[2]), 0);
        chk("sup_sq2", 32'(bus.sq[2]), 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("sup_next2", 32'(bus.tick[2]), 32'(k % 4 == 0));
        end

        // Staggered starts aligned by sync_start
        wr(0, 7, 0, 1);
        repeat (2) step();
        wr(3, 7, 0, 1);
        step();
        bus.sync_start = 1'b1;
        step();
        bus.sync_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("sync_t0", 32'(bus.tick[0]), 32'(k == 8));
            chk("sync_t3", 32'(bus.tick[3]), 32'(k == 8));
        end

        // Out-of-range channel on a 3-channel instance
        sbus.cfg_we = 1; sbus.cfg_ch = 2'd3;
        sbus.cfg_div = 4'd0; sbus.cfg_en = 1;
        step();
        sbus.cfg_we = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("oor_busy", 32'(sbus.busy), 0);
            chk("oor_tick", 32'(sbus.tick), 0);
        end
        sbus.cfg_we = 1; sbus.cfg_ch = 2'd2;
        step();
        sbus.cfg_we = 0;
        chk("inr_busy", 32'(sbus.busy), 32'b100);
        step();
        chk("inr_tick", 32'(sbus.tick), 32'b100);

        // Asynchronous reset mid-count
        chk("pre_rst_busy", 32'(bus.busy), 32'b1101);
        rst_n = 1'b0;
        #1;
        chk("arst_tick", 32'(bus.tick), 0);
        chk("arst_sq", 32'(bus.sq), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_sbusy", 32'(sbus.busy), 0);
        step();
        rst_n = 1'b1;
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            acc |= {bus.tick, bus.sq, bus.busy};
        end
        chk("post_rst_idle", 32'(acc), 0);
        wr(0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("div0_tick", 32'(bus.tick[0]), 1);
            chk("div0_sq", 32'(bus.sq[0]), 32'(k % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
